// File: rtl/rv_pkg.sv
// Shared constants, state encoding and the legality rule for the RV32I subset
// handled by the multi-cycle sequencer.
package rv_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] R_IMM  = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LH      = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // Only the encodings the companion decoder implements are accepted.
  function automatic logic is_legal(input logic [6:0] opcode,
                                    input logic [2:0] f3,
                                    input logic [6:0] f7);
    logic ok;
    ok = 1'b0;
    case (opcode)
      R_TYPE:  ok = ((f3 == F3_ADD_SUB) && ((f7 == F7_BASE) || (f7 == F7_ALT))) ||
                    (((f3 == F3_OR) || (f3 == F3_AND)) && (f7 == F7_BASE));
      R_IMM:   ok = (f3 == F3_ADD_SUB) || (f3 == F3_XOR) || (f3 == F3_OR) || (f3 == F3_AND);
      LOAD:    ok = (f3 == F3_LW) || (f3 == F3_LH);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ld_extend.sv
// Load-data formatter: passes a word through for lw, sign-extends the low
// halfword for lh.
module ld_extend
  import rv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  // Select load formatting by funct3
  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_LH:   data_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
      F3_LW:   data_o = rdata_i;
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with sticky trap on any
// encoding outside the supported subset.
module rv_multicycle_ctrl
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_valid,
  input  logic [31:0] alu_result,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] wb_data,
  output logic        retire,
  output logic        illegal,
  output logic [2:0]  state
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] res_q, res_d;
  logic        illegal_q, illegal_d;
  logic [31:0] ld_data_s;

  ld_extend u_ld_extend (
    .funct3_i (ir_q[14:12]),
    .rdata_i  (dmem_rdata),
    .data_o   (ld_data_s)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0000_0000;
      res_q     <= 32'h0000_0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      res_q     <= res_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic; strobes depend on the current state only
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    res_d     = res_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    rf_we     = 1'b0;
    retire    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (is_legal(ir_q[6:0], ir_q[14:12], ir_q[31:25])) begin
          state_d = ST_EXEC;
        end else begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end
      end
      ST_EXEC: begin
        res_d = alu_result;
        if (ir_q[6:0] == LOAD) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        if (dmem_valid) begin
          res_d   = ld_data_s;
          state_d = ST_WB;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        rf_we   = (ir_q[11:7] != 5'd0);
        retire  = 1'b1;
        pc_d    = pc_q + 32'd4;
        state_d = ST_FETCH;
      end
      ST_TRAP: begin
        state_d   = ST_TRAP;
        illegal_d = 1'b1;
      end
      default: begin
        // Unreachable encodings are treated as a trap rather than silently recovered.
        state_d   = ST_TRAP;
        illegal_d = 1'b1;
      end
    endcase
  end

  assign imem_addr = pc_q;
  assign dmem_addr = res_q;
  assign ir        = ir_q;
  assign pc        = pc_q;
  assign rf_waddr  = ir_q[11:7];
  assign wb_data   = res_q;
  assign illegal   = illegal_q;
  assign state     = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench: an instruction-level model predicts every output on every
// cycle; a second instance with a high reset PC exercises PC wrap-around.
module tb_rv_multicycle_ctrl;

  localparam logic [31:0] PC_A  = 32'h0000_0100;
  localparam logic [31:0] PC_B  = 32'hFFFF_FFF4;
  localparam logic [31:0] DELTA = PC_B - PC_A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_rdata = 32'h0, dmem_rdata = 32'h0, alu_result = 32'h0;
  logic        imem_valid = 1'b0, dmem_valid = 1'b0;

  logic        imem_req, dmem_req, rf_we, retire, illegal;
  logic [31:0] imem_addr, dmem_addr, ir, pc, wb_data;
  logic [4:0]  rf_waddr;
  logic [2:0]  state;

  logic        b_imem_req, b_dmem_req, b_rf_we, b_retire, b_illegal;
  logic [31:0] b_imem_addr, b_dmem_addr, b_ir, b_pc, b_wb_data;
  logic [4:0]  b_rf_waddr;
  logic [2:0]  b_state;

  rv_multicycle_ctrl #(.RESET_PC(PC_A)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid),
    .alu_result(alu_result), .ir(ir), .pc(pc), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .wb_data(wb_data), .retire(retire), .illegal(illegal), .state(state)
  );

  rv_multicycle_ctrl #(.RESET_PC(PC_B)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .dmem_req(b_dmem_req), .dmem_addr(b_dmem_addr), .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid),
    .alu_result(alu_result), .ir(b_ir), .pc(b_pc), .rf_we(b_rf_we), .rf_waddr(b_rf_waddr),
    .wb_data(b_wb_data), .retire(b_retire), .illegal(b_illegal), .state(b_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int instr_start = 0;
  int retire_at = -1;
  int ret_cnt = 0;
  int we_cnt = 0;
  logic [31:0] last_wb = 32'h0;
  logic [4:0]  last_waddr = 5'd0;

  // Model state: architectural values the outputs must reflect
  logic [31:0] m_pc = PC_A, m_ir = 32'h0, m_res = 32'h0;
  logic        m_illegal = 1'b0;
  bit          chk_en = 1'b0;
  logic [2:0]  e_state = 3'd0;
  logic        e_ireq = 1'b0, e_dreq = 1'b0, e_we = 1'b0, e_ret = 1'b0;

  logic [16:0] r_keys [4] = '{{7'h00, 3'd0, 7'h33}, {7'h20, 3'd0, 7'h33},
                              {7'h00, 3'd6, 7'h33}, {7'h00, 3'd7, 7'h33}};
  logic [9:0]  i_keys [6] = '{{3'd0, 7'h13}, {3'd4, 7'h13}, {3'd6, 7'h13},
                              {3'd7, 7'h13}, {3'd2, 7'h03}, {3'd1, 7'h03}};

  function automatic bit m_legal(input logic [31:0] i);
    bit ok = 1'b0;
    for (int k = 0; k < 4; k++) if ({i[31:25], i[14:12], i[6:0]} == r_keys[k]) ok = 1'b1;
    for (int k = 0; k < 6; k++) if ({i[14:12], i[6:0]} == i_keys[k]) ok = 1'b1;
    return ok;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_n, act, exp);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (retire) begin ret_cnt++; retire_at = cyc_n; last_wb = wb_data; end
    if (rf_we) begin we_cnt++; last_waddr = rf_waddr; end
    if (chk_en) begin
      chk("state", state, e_state);
      chk("imem_req", imem_req, e_ireq);
      chk("dmem_req", dmem_req, e_dreq);
      chk("rf_we", rf_we, e_we);
      chk("retire", retire, e_ret);
      chk("illegal", illegal, m_illegal);
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("ir", ir, m_ir);
      chk("rf_waddr", rf_waddr, m_ir[11:7]);
      chk("wb_data", wb_data, m_res);
      if (e_dreq) chk("dmem_addr", dmem_addr, m_res);
      chk("b_pc", b_pc, m_pc + DELTA);
      chk("b_imem_addr", b_imem_addr, m_pc + DELTA);
      chk("b_state", b_state, e_state);
      chk("b_retire", b_retire, e_ret);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic [2:0] st, input logic ireq, input logic dreq,
                         input logic we, input logic ret);
    e_state = st; e_ireq = ireq; e_dreq = dreq; e_we = we; e_ret = ret;
  endtask

  // Called with rst_n already low: checks reset values, resets the model, releases reset
  task automatic reset_tail();
    chk_en = 1'b0;
    chk("rst_state", state, 3'd0);
    chk("rst_imem_req", imem_req, 1'b1);
    chk("rst_imem_addr", imem_addr, 32'h0000_0100);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_retire", retire, 1'b0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_b_pc", b_pc, 32'hFFFF_FFF4);
    m_pc = PC_A; m_ir = 32'h0; m_res = 32'h0; m_illegal = 1'b0;
    imem_valid = 1'b0; dmem_valid = 1'b0;
    set_exp(3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk_en = 1'b1;
  endtask

  // Drives one instruction through the sequencer with the given memory waits
  task automatic run_instr(input logic [31:0] instr, input int iw, input int dw,
                           input logic [31:0] alu, input logic [31:0] drd, input bit abort);
    bit lg = m_legal(instr);
    bit ld = (instr[6:0] == 7'b0000011);
    int rsnap;
    instr_start = cyc_n;
    for (int i = 0; i <= iw; i++) begin
      imem_valid = (i == iw);
      imem_rdata = (i == iw) ? instr : 32'hDEAD_0000 + i;
      set_exp(3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
    end
    m_ir = instr;
    imem_valid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    set_exp(3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    if (!lg) begin
      m_illegal = 1'b1;
      dmem_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
        set_exp(3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
      end
      return;
    end
    alu_result = alu;
    set_exp(3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    m_res = alu;
    if (ld) begin
      for (int j = 0; j <= dw; j++) begin
        dmem_valid = (j == dw);
        dmem_rdata = (j == dw) ? drd : 32'h5555_AAAA;
        set_exp(3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        if (abort && j == 1) begin
          chk_en = 1'b0;
          rsnap = ret_cnt;
          #1 rst_n = 1'b0;
          #1;
          chk("abort_dmem_req", dmem_req, 1'b0);
          chk("abort_pc", pc, 32'h0000_0100);
          reset_tail();
          chk("abort_no_retire", ret_cnt, rsnap);
          return;
        end
        cyc();
      end
      if (instr[14:12] == 3'b001)
        m_res = drd[15] ? (drd | 32'hFFFF_0000) : (drd & 32'h0000_FFFF);
      else
        m_res = drd;
    end
    set_exp(3'd4, 1'b0, 1'b0, (instr[11:7] != 5'd0), 1'b1);
    cyc();
    m_pc = m_pc + 32'd4;
    imem_valid = 1'b0; dmem_valid = 1'b0;
    set_exp(3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int wsnap;
    repeat (2) @(posedge clk);
    #1;
    reset_tail();

    // add x3,x1,x2: zero-wait, four cycles
    run_instr(32'h0020_81B3, 0, 0, 32'd7, 32'h0, 1'b0);
    chk("add_retire_cycle", retire_at - instr_start + 1, 32'd4);
    chk("add_wb_data", last_wb, 32'd7);
    chk("add_waddr", last_waddr, 32'd3);
    chk("add_next_pc", pc, 32'h0000_0104);

    // lh x5 with three dmem wait cycles
    run_instr(32'h0000_9283, 0, 3, 32'h0000_0040, 32'h0000_8001, 1'b0);
    chk("lh_retire_cycle", retire_at - instr_start + 1, 32'd8);
    chk("lh_wb_data", last_wb, 32'hFFFF_8001);

    // addi x0,x0,5: retires without a register write; instance B wraps to 0
    wsnap = we_cnt;
    run_instr(32'h0050_0013, 2, 0, 32'd5, 32'h0, 1'b0);
    chk("x0_no_we", we_cnt, wsnap);
    chk("x0_retire_cycle", retire_at - instr_start + 1, 32'd6);
    chk("wrap_b_pc", b_pc, 32'h0000_0000);

    run_instr(32'h0000_A383, 1, 1, 32'h2000_0010, 32'h8765_4321, 1'b0);
    chk("lw_wb_data", last_wb, 32'h8765_4321);
    run_instr(32'h4020_8233, 0, 0, 32'hFFFF_FFFF, 32'h0, 1'b0);
    run_instr(32'h0000_9283, 0, 0, 32'h0000_0044, 32'h1234_7FFF, 1'b0);
    chk("lh_pos_wb_data", last_wb, 32'h0000_7FFF);
    run_instr(32'h0020_E333, 1, 0, 32'h0000_00F3, 32'h0, 1'b0);
    run_instr(32'h00F0_F413, 0, 0, 32'h0000_000A, 32'h0, 1'b0);
    run_instr(32'h0FF0_C493, 0, 0, 32'h1234_5678, 32'h0, 1'b0);
    run_instr(32'h0010_E513, 0, 0, 32'h0000_0001, 32'h0, 1'b0);

    // Reset during MEM of a lw
    run_instr(32'h0000_A383, 0, 5, 32'h0000_0300, 32'h0, 1'b1);

    // slti is outside the subset: trap, no write, fetches stop
    wsnap = we_cnt;
    run_instr(32'h0000_2013, 0, 0, 32'h0, 32'h0, 1'b0);
    chk("trap_illegal", illegal, 1'b1);
    chk("trap_imem_req", imem_req, 1'b0);
    chk("trap_no_we", we_cnt, wsnap);
    chk_en = 1'b0; rst_n = 1'b0; #1;
    reset_tail();

    // R-type with an unsupported funct3/funct7 pairing also traps
    run_instr(32'h4020_E233, 1, 0, 32'h0, 32'h0, 1'b0);
    chk_en = 1'b0; rst_n = 1'b0; #1;
    reset_tail();

    run_instr(32'h0020_81B3, 0, 0, 32'd9, 32'h0, 1'b0);
    chk("recover_pc", pc, 32'h0000_0104);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Multi-cycle sequencer for the RV32I subset core: fetches an instruction, presents it to the instruction decoder via `ir`, steps through execute, optional memory and writeback, then advances the PC. It owns the instruction- and data-memory request handshakes, the register-file write strobe and the writeback data path. The decoder and ALU sit beside it in the datapath. It supports the subset the decoder handles: add/sub/or/and, addi/xori/ori/andi, lw/lh. Any other encoding traps.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value after reset.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `imem_req`  out  1: instruction fetch request.
- `imem_addr`  out  32: fetch address, equal to `pc`.
- `imem_rdata`  in  32: fetched instruction.
- `imem_valid`  in  1: `imem_rdata` is valid.
- `dmem_req`  out  1: load request.
- `dmem_addr`  out  32: load address, equal to the latched ALU result.
- `dmem_rdata`  in  32: load data.
- `dmem_valid`  in  1: `dmem_rdata` is valid.
- `alu_result`  in  32: ALU output from the datapath.
- `ir`  out  32: latched instruction, feeds the decoder.
- `pc`  out  32: current PC.
- `rf_we`  out  1: register-file write enable.
- `rf_waddr`  out  5: destination register, `ir[11:7]`.
- `wb_data`  out  32: writeback data.
- `retire`  out  1: one-cycle pulse per completed instruction.
- `illegal`  out  1: sticky trap flag.
- `state`  out  3: current state, for debug.

## Operation
States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- **FETCH**
  - `imem_req`=1 for the whole state.
  - The first cycle with `imem_valid`=1 latches `ir`<=`imem_rdata` and moves to DECODE.
  - `imem_valid` is ignored in every other state.
- **DECODE** (1 cycle): checks legality.
  - opcode 0110011 with {funct3,funct7} in {000/0000000, 000/0100000, 110/0000000, 111/0000000}.
  - opcode 0010011 with funct3 in {000,100,110,111}.
  - opcode 0000011 with funct3 in {010,001}.
  - Legal -> EXEC. Otherwise -> TRAP.
- **EXEC** (1 cycle): `res`<=`alu_result`. Load -> MEM, else -> WB.
- **MEM**
  - `dmem_req`=1 and `dmem_addr`=`res` for the whole state.
  - The first cycle with `dmem_valid` latches `res`:
    - lw: `dmem_rdata`.
    - lh: `{{16{dmem_rdata[15]}}, dmem_rdata[15:0]}`.
  - Then -> WB.
- **WB** (1 cycle)
  - `wb_data`=`res`.
  - `rf_we` = (`rf_waddr` != 0).
  - `retire`=1; `pc`<=`pc`+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - -> FETCH.
- **TRAP**
  - `illegal`=1 and no requests are issued.
  - `pc` and `ir` are frozen. Exit is only by reset.

Strobes (`imem_req`, `dmem_req`, `rf_we`, `retire`) are decoded from `state` alone, never from `imem_valid` or `dmem_valid`. `wb_data` equals `res` in all states.

## Timing
- **Reset values:** `state`=FETCH, `pc`=`RESET_PC`, `ir`=0, `res`=0, `illegal`=0.
  - As a result, `imem_req`=1 immediately after reset and `imem_addr`=`RESET_PC`.
  - All other strobes are 0.
- **Reset mid-operation:** `rst_n` low aborts immediately and asynchronously. Outstanding memory requests drop without completing, and no writeback occurs.
- **Zero-wait memory** (valid in the first request cycle):
  - ALU ops take 4 cycles.
  - Loads take 5 cycles.
  - Each wait cycle on `imem_valid` or `dmem_valid` adds exactly one cycle.
- **Write timing:** `rf_we` and `retire` are high for exactly one cycle per instruction. The new `pc` is visible the cycle after WB, as the first FETCH cycle.
- **Decoder timing:** decoder outputs derived from `ir` are stable from DECODE through WB. `ir` changes only on a FETCH accept.

## Structure
- Package `rv_pkg` holds:
  - opcode constants (R_TYPE, R_IMM, LOAD);
  - funct3 constants;
  - the state enum;
  - `RESET_PC` default.
- Sub-module `ld_extend` performs combinational lw/lh formatting, selected by funct3.
- The decoder and ALU are instantiated by the datapath top, not inside this block.

## Test plan
- **Reset fetch:** reset with `RESET_PC`=0x100, zero-wait imem returning `add x3,x1,x2` (0x002081B3), `alu_result`=7.
  - -> `imem_addr`=0x100.
  - -> `rf_we` in cycle 4 with `rf_waddr`=3 and `wb_data`=7.
  - -> `pc`=0x104 in cycle 5.
- **lh with waits:** lh x5 (funct3 001), `dmem_valid` delayed 3 cycles, `dmem_rdata`=0x0000_8001.
  - -> `wb_data`=0xFFFF_8001.
  - -> `retire` at cycle 8.
- **Illegal encoding:** 0x00000013 with funct3 forced to 010 (slti, 0x00002013).
  - -> TRAP after DECODE.
  - -> `illegal`=1, no `rf_we`, `imem_req`=0 forever.
- **Write to x0:** `addi x0,x0,5` -> `retire`=1 and `rf_we`=0.
- **PC wrap and reset abort:**
  - `pc`=0xFFFF_FFFC completing a legal op -> next `pc`=0.
  - Assert `rst_n` during MEM -> `dmem_req` drops the same cycle, `pc`=`RESET_PC`, no `retire`.
